fp_writeback_arbiter: RTL

- Merges result streams from the FP multiply pipeline and the FP add/sub pipeline into the single register-file write port of the co-processor.
- Each pipeline presents a one-cycle result pulse: done, 32-bit result and 4-bit destination register. Pipelines cannot stall, so the block buffers results that collide.
- Buffering is an in-order skid FIFO. The block raises a stall request toward the issue stage before the FIFO can overflow.

---
 rtl/fp_writeback_arbiter_if.sv | 31 +++
 rtl/fp_writeback_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp_writeback_arbiter_if.sv
// Bundle between the FP result pipelines and the register-file write port.
// The master side produces results; the arbiter sits on the slave side.
interface fp_writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mul_done;
  logic [31:0]   mul_result;
  logic [3:0]    mul_dest;
  logic          add_done;
  logic [31:0]   add_result;
  logic [3:0]    add_dest;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          wr_nan;
  logic          stall;
  logic          ovf;
  logic [CW-1:0] count;

  modport master (
    output mul_done, mul_result, mul_dest, add_done, add_result, add_dest,
    input  wr_en, wr_addr, wr_data, wr_nan, stall, ovf, count
  );

  modport slave (
    input  mul_done, mul_result, mul_dest, add_done, add_result, add_dest,
    output wr_en, wr_addr, wr_data, wr_nan, stall, ovf, count
  );
endinterface

// File: rtl/fp_writeback_arbiter.sv
// Merges FP multiply and add/sub result pulses onto one register-file write port.
// Colliding results go to an in-order skid FIFO; the oldest pending result always wins.
module fp_writeback_arbiter #(
  parameter int DEPTH     = 4,
  parameter int STALL_LVL = 2
) (
  input logic                  clk,
  input logic                  nrst,
  fp_writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_p1;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          wr_nan_q, wr_nan_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;

  entry_t head_e, mul_e, add_e, sel_e, req0_e, req1_e;
  logic   pop, sel_valid, req0, req1, acc0, acc1;
  int     free_slots;

  always_comb begin
    head_e      = mem[rptr_q];
    mul_e.dest  = bus.mul_dest;
    mul_e.data  = bus.mul_result;
    add_e.dest  = bus.add_dest;
    add_e.data  = bus.add_result;
    pop         = 1'b0;
    sel_valid   = 1'b0;
    sel_e       = head_e;
    req0        = 1'b0;
    req1        = 1'b0;
    req0_e      = mul_e;
    req1_e      = add_e;

    // Priority is age: buffered head, then mul, then add. Losers queue in that order.
    if (count_q != '0) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_e     = head_e;
      if (bus.mul_done) begin
        req0 = 1'b1;
        req1 = bus.add_done;
      end else if (bus.add_done) begin
        req0   = 1'b1;
        req0_e = add_e;
      end
    end else if (bus.mul_done) begin
      sel_valid = 1'b1;
      sel_e     = mul_e;
      req0      = bus.add_done;
      req0_e    = add_e;
    end else if (bus.add_done) begin
      sel_valid = 1'b1;
      sel_e     = add_e;
    end

    // The pop releases its slot before this edge's pushes claim space.
    free_slots = DEPTH - int'(count_q) + (pop ? 1 : 0);
    acc0       = req0 && (free_slots >= 1);
    acc1       = req1 && (free_slots >= 2);

    count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    wptr_d  = wptr_q + AW'(acc0) + AW'(acc1);
    wptr_p1 = wptr_q + AW'(1);
    rptr_d  = rptr_q + AW'(pop);

    wr_en_d   = sel_valid;
    wr_addr_d = sel_valid ? sel_e.dest : wr_addr_q;
    wr_data_d = sel_valid ? sel_e.data : wr_data_q;
    wr_nan_d  = sel_valid && (sel_e.data[30:23] == 8'hFF) && (sel_e.data[22:0] != 23'd0);
    stall_d   = (DEPTH - int'(count_d)) <= STALL_LVL;
    ovf_d     = ovf_q || (req0 && !acc0) || (req1 && !acc1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_nan_q  <= 1'b0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_nan_q  <= wr_nan_d;
      stall_q   <= stall_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (acc0) mem[wptr_q]  <= req0_e;
    if (acc1) mem[wptr_p1] <= req1_e;
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_nan  = wr_nan_q;
  assign bus.stall   = stall_q;
  assign bus.ovf     = ovf_q;
  assign bus.count   = count_q;
endmodule
